// File: rtl/axi_lite_dmem.sv
// axi_lite_dmem: AXI4-Lite slave data memory on the core load/store port.
// Build option: define DMEM_WSTRB_EN to honour WSTRB byte lanes on writes.
module axi_lite_dmem #(
  parameter int    ADDR_WIDTH = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        AXI_AWVALID,
  output logic        AXI_AWREADY,
  input  logic [31:0] AXI_AWADDR,
  input  logic [2:0]  AXI_AWPROT,
  input  logic        AXI_WVALID,
  output logic        AXI_WREADY,
  input  logic [31:0] AXI_WDATA,
  input  logic [3:0]  AXI_WSTRB,
  output logic        AXI_BVALID,
  input  logic        AXI_BREADY,
  output logic [1:0]  AXI_BRESP,
  input  logic        AXI_ARVALID,
  output logic        AXI_ARREADY,
  input  logic [31:0] AXI_ARADDR,
  input  logic [2:0]  AXI_ARPROT,
  output logic        AXI_RVALID,
  input  logic        AXI_RREADY,
  output logic [31:0] AXI_RDATA,
  output logic [1:0]  AXI_RRESP
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] { W_IDLE, W_MEM, W_RESP } w_state_e;
  typedef enum logic [1:0] { R_IDLE, R_MEM, R_DATA } r_state_e;

  logic [31:0] mem [DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic                  w_oor_q, w_oor_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic                  r_oor_q, r_oor_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic w_gnt, r_gnt, mem_we;
  logic unused_ok;

  assign aw_hs  = AXI_AWVALID && awready_q;
  assign w_hs   = AXI_WVALID && wready_q;
  assign ar_hs  = AXI_ARVALID && arready_q;
  // Single RAM port: a pending write always beats a pending read.
  assign w_gnt  = (w_state_q == W_MEM);
  assign r_gnt  = (r_state_q == R_MEM) && !w_gnt;
  assign mem_we = rst_n && w_gnt && !w_oor_q;

  assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0],
                       AXI_ARADDR[1:0], wstrb_q};

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    w_idx_d   = w_idx_q;
    w_oor_d   = w_oor_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          w_idx_d   = AXI_AWADDR[ADDR_WIDTH+1:2];
          w_oor_d   = |AXI_AWADDR[31:ADDR_WIDTH+2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = AXI_WDATA;
          wstrb_d  = AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_MEM;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_MEM: begin
        if (w_gnt) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = w_oor_q ? 2'b10 : 2'b00;
        end
      end
      W_RESP: begin
        if (AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = 2'b00;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    r_idx_d   = r_idx_q;
    r_oor_d   = r_oor_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_MEM;
          arready_d = 1'b0;
          r_idx_d   = AXI_ARADDR[ADDR_WIDTH+1:2];
          r_oor_d   = |AXI_ARADDR[31:ADDR_WIDTH+2];
        end else begin
          arready_d = 1'b1;
        end
      end
      R_MEM: begin
        if (r_gnt) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = r_oor_q ? 32'h0 : mem[r_idx_q];
          rresp_d   = r_oor_q ? 2'b10 : 2'b00;
        end
      end
      R_DATA: begin
        if (AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      w_idx_q   <= '0;
      w_oor_q   <= 1'b0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      r_idx_q   <= '0;
      r_oor_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      w_idx_q   <= w_idx_d;
      w_oor_q   <= w_oor_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      r_idx_q   <= r_idx_d;
      r_oor_q   <= r_oor_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef DMEM_WSTRB_EN
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[w_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
`else
      mem[w_idx_q] <= wdata_q;
`endif
    end
  end

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_ARREADY = arready_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_axi_lite_dmem.sv
// tb_axi_lite_dmem: directed and random AXI4-Lite traffic against
// a word-array reference model of the data memory.
module tb_axi_lite_dmem;
  logic        clk;
  logic        rst_n;
  logic        AXI_AWVALID, AXI_AWREADY;
  logic [31:0] AXI_AWADDR;
  logic [2:0]  AXI_AWPROT;
  logic        AXI_WVALID, AXI_WREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_BVALID, AXI_BREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_ARVALID, AXI_ARREADY;
  logic [31:0] AXI_ARADDR;
  logic [2:0]  AXI_ARPROT;
  logic        AXI_RVALID, AXI_RREADY;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  axi_lite_dmem dut (
    .clk(clk), .rst_n(rst_n),
    .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
    .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_BRESP(AXI_BRESP),
    .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: sparse word store, 16-bit byte address space in range.
  logic [31:0] ref_mem [int];

  function automatic logic [1:0] ref_write(input logic [31:0] addr,
                                           input logic [31:0] data,
                                           input logic [3:0]  strb);
    logic [31:0] cur, mask;
    int w;
    if (addr[31:16] != 16'h0) return 2'b10;
    w = int'(addr[15:2]);
    cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
`ifndef DMEM_WSTRB_EN
    mask = 32'hFFFF_FFFF;
`endif
    ref_mem[w] = (cur & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  task automatic ref_read(input logic [31:0] addr,
                          output logic [31:0] data, output logic [1:0] resp);
    if (addr[31:16] != 16'h0) begin
      data = 32'h0;
      resp = 2'b10;
    end else begin
      data = ref_mem[int'(addr[15:2])];
      resp = 2'b00;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly,
                          input int w_dly, input int b_dly,
                          output logic [1:0] resp, output int lat);
    int t = 0;
    int n = 0;
    int hs_cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    logic [1:0] r0;
    AXI_AWADDR = addr;
    AXI_WDATA  = data;
    AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && t < 40) begin
      AXI_AWVALID = !aw_done && (t >= aw_dly);
      AXI_WVALID  = !w_done && (t >= w_dly);
      if (aw_done != w_done) begin
        check("split_ready_held", aw_done ? AXI_AWREADY : AXI_WREADY, 0);
        check("split_ready_open", aw_done ? AXI_WREADY : AXI_AWREADY, 1);
      end
      aw_hs = AXI_AWVALID && AXI_AWREADY;
      w_hs  = AXI_WVALID && AXI_WREADY;
      if (aw_hs || w_hs) hs_cyc = cyc;
      tick();
      t++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
    end
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    check("wr_hs_timeout", aw_done && w_done, 1);
    while (!AXI_BVALID && n < 20) begin
      tick();
      n++;
    end
    check("bvalid_timeout", AXI_BVALID, 1);
    lat = cyc - hs_cyc;
    r0 = AXI_BRESP;
    for (int i = 0; i < b_dly; i++) begin
      check("b_hold_valid", AXI_BVALID, 1);
      check("b_hold_resp", AXI_BRESP, r0);
      check("b_hold_no_aw", AXI_AWREADY, 0);
      tick();
    end
    AXI_BREADY = 1'b1;
    resp = AXI_BRESP;
    tick();
    AXI_BREADY = 1'b0;
    check("b_done_valid", AXI_BVALID, 0);
    check("b_done_ready", {AXI_AWREADY, AXI_WREADY}, 2'b11);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int lat);
    int n = 0;
    int hs_cyc;
    AXI_ARADDR  = addr;
    AXI_ARVALID = 1'b1;
    while (!AXI_ARREADY && n < 20) begin
      tick();
      n++;
    end
    check("arready_timeout", AXI_ARREADY, 1);
    hs_cyc = cyc;
    tick();
    AXI_ARVALID = 1'b0;
    n = 0;
    while (!AXI_RVALID && n < 20) begin
      tick();
      n++;
    end
    check("rvalid_timeout", AXI_RVALID, 1);
    lat  = cyc - hs_cyc;
    data = AXI_RDATA;
    resp = AXI_RRESP;
    for (int i = 0; i < r_dly; i++) begin
      check("r_hold_valid", AXI_RVALID, 1);
      check("r_hold_data", AXI_RDATA, data);
      check("r_hold_resp", AXI_RRESP, resp);
      check("r_hold_no_ar", AXI_ARREADY, 0);
      tick();
    end
    AXI_RREADY = 1'b1;
    tick();
    AXI_RREADY = 1'b0;
    check("r_done_valid", AXI_RVALID, 0);
    check("r_done_arready", AXI_ARREADY, 1);
  endtask

  logic [31:0] addr, data, exp_d, rd;
  logic [3:0]  strb;
  logic [1:0]  exp_r, wr_resp, rr;
  int          wl, rl;

  initial begin
    rst_n = 1'b0;
    AXI_AWVALID = 0; AXI_AWADDR = 0; AXI_AWPROT = 3'b010;
    AXI_WVALID = 0; AXI_WDATA = 0; AXI_WSTRB = 0; AXI_BREADY = 0;
    AXI_ARVALID = 0; AXI_ARADDR = 0; AXI_ARPROT = 3'b001; AXI_RREADY = 0;
    repeat (3) tick();
    check("rst_awready", AXI_AWREADY, 0);
    check("rst_wready", AXI_WREADY, 0);
    check("rst_arready", AXI_ARREADY, 0);
    check("rst_bvalid", AXI_BVALID, 0);
    check("rst_rvalid", AXI_RVALID, 0);
    check("rst_bresp", AXI_BRESP, 0);
    check("rst_rresp", AXI_RRESP, 0);
    check("rst_rdata", AXI_RDATA, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // AW and W together, then read back.
    exp_r = ref_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, wr_resp, wl);
    check("wr1_resp", wr_resp, exp_r);
    check("wr1_lat", wl, 2);
    do_read(32'h10, 0, rd, rr, rl);
    check("rd1_data", rd, 32'hDEADBEEF);
    check("rd1_resp", rr, 2'b00);
    check("rd1_lat", rl, 2);

    // W three cycles ahead of AW.
    exp_r = ref_write(32'h40, 32'h12345678, 4'hF);
    do_write(32'h40, 32'h12345678, 4'hF, 3, 0, 0, wr_resp, wl);
    check("wr2_lat", wl, 2);
    do_read(32'h40, 0, rd, rr, rl);
    check("rd2_data", rd, 32'h12345678);

    // Byte strobes.
    exp_r = ref_write(32'h20, 32'hAABBCCDD, 4'hF);
    do_write(32'h20, 32'hAABBCCDD, 4'hF, 0, 0, 0, wr_resp, wl);
    exp_r = ref_write(32'h20, 32'h11223344, 4'b0101);
    do_write(32'h20, 32'h11223344, 4'b0101, 1, 0, 0, wr_resp, wl);
    check("strb_resp", wr_resp, exp_r);
    do_read(32'h20, 0, rd, rr, rl);
`ifdef DMEM_WSTRB_EN
    check("strb_data", rd, 32'hAA22CC44);
`else
    check("strb_data", rd, 32'h11223344);
`endif
    ref_read(32'h20, exp_d, exp_r);
    check("strb_model", rd, exp_d);

    // Out of range write aliases word 0 but must not touch it.
    exp_r = ref_write(32'h0, 32'h01020304, 4'hF);
    do_write(32'h0, 32'h01020304, 4'hF, 0, 0, 0, wr_resp, wl);
    exp_r = ref_write(32'h0001_0000, 32'hFFFFFFFF, 4'hF);
    do_write(32'h0001_0000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, wr_resp, wl);
    check("oor_bresp", wr_resp, exp_r);
    check("oor_bresp_lit", wr_resp, 2'b10);
    do_read(32'h0, 0, rd, rr, rl);
    check("oor_word0", rd, 32'h01020304);
    do_read(32'h0001_0000, 0, rd, rr, rl);
    check("oor_rdata", rd, 32'h0);
    check("oor_rresp", rr, 2'b10);

    // Write and read of the same word collide on the RAM port.
    repeat (2) tick();
    exp_r = ref_write(32'h8, 32'h5, 4'hF);
    fork
      do_write(32'h8, 32'h5, 4'hF, 0, 0, 0, wr_resp, wl);
      do_read(32'h8, 0, rd, rr, rl);
    join
    check("coll_wr_lat", wl, 2);
    check("coll_rd_lat", rl, 3);
    check("coll_rd_data", rd, 32'h5);

    // Backpressure on B and R.
    data = $urandom;
    exp_r = ref_write(32'h44, data, 4'hF);
    do_write(32'h44, data, 4'hF, 0, 0, 5, wr_resp, wl);
    check("stall_bresp", wr_resp, exp_r);
    do_read(32'h44, 5, rd, rr, rl);
    check("stall_rdata", rd, data);

    // Reset while the write sits in W_MEM.
    repeat (2) tick();
    AXI_AWADDR = 32'h10; AXI_WDATA = 32'hCAFEF00D; AXI_WSTRB = 4'hF;
    AXI_AWVALID = 1; AXI_WVALID = 1; AXI_BREADY = 1;
    check("rst_wmem_rdy", {AXI_AWREADY, AXI_WREADY}, 2'b11);
    tick();
    AXI_AWVALID = 0; AXI_WVALID = 0;
    rst_n = 1'b0;
    tick();
    check("rst_wmem_bvalid", AXI_BVALID, 0);
    check("rst_wmem_awready", AXI_AWREADY, 0);
    check("rst_wmem_rdata", AXI_RDATA, 0);
    rst_n = 1'b1;
    AXI_BREADY = 0;
    for (int i = 0; i < 4; i++) begin
      check("rst_wmem_no_b", AXI_BVALID, 0);
      tick();
    end
    do_read(32'h10, 0, rd, rr, rl);
    ref_read(32'h10, exp_d, exp_r);
    check("rst_wmem_word", rd, exp_d);

    // Random traffic over a small word window plus stray out-of-range.
    for (int i = 0; i < 16; i++) begin
      addr = 32'h400 + 32'(i * 4);
      data = $urandom;
      exp_r = ref_write(addr, data, 4'hF);
      do_write(addr, data, 4'hF, 0, 0, 0, wr_resp, wl);
    end
    for (int it = 0; it < 48; it++) begin
      addr = 32'h400 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        addr = $urandom;
        if (addr[31:16] == 16'h0) addr[31] = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        exp_r = ref_write(addr, data, strb);
        do_write(addr, data, strb, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), wr_resp, wl);
        check("rnd_bresp", wr_resp, exp_r);
        check("rnd_wlat", wl, 2);
      end else begin
        ref_read(addr, exp_d, exp_r);
        do_read(addr, $urandom_range(0, 2), rd, rr, rl);
        check("rnd_rdata", rd, exp_d);
        check("rnd_rresp", rr, exp_r);
        check("rnd_rlat", rl, 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
